// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits num pulses of hi_len high / lo_len low cycles, then a done strobe
module pulse_train_gen #(
  parameter int CNT_W = 4,
  parameter int TW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num,
  input  logic [TW-1:0]    hi_len,
  input  logic [TW-1:0]    lo_len,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
  state_t state, state_n;
  logic [TW-1:0] tmr, tmr_n, hi_q, lo_q, hi_src;
  logic [CNT_W-1:0] num_q;
  logic acc, fin;
  // next state, phase timer reload/countdown and status decodes
  always_comb begin
    acc = (state == IDLE) && start;
    fin = (tmr == '0);
    hi_src = acc ? hi_len : hi_q;
    state_n = state;
    case (state)
      IDLE: state_n = acc ? ((num == '0) ? DONE : HIGH) : IDLE;
      HIGH: state_n = fin ? LOW : HIGH;
      LOW:  state_n = fin ? ((sent < num_q) ? HIGH : DONE) : LOW;
      DONE: state_n = IDLE;
    endcase
    tmr_n = fin ? '0 : tmr - TW'(1);
    if (state_n == HIGH && state != HIGH)
      tmr_n = (hi_src == '0) ? '0 : hi_src - TW'(1);
    if (state_n == LOW && state != LOW)
      tmr_n = (lo_q == '0) ? '0 : lo_q - TW'(1);
    busy = (state != IDLE);
    done = (state == DONE);
  end
  // state, timer, latched train parameters, pulse count and registered output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tmr   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      num_q <= '0;
      sent  <= '0;
      out   <= 1'b0;
    end else begin
      state <= state_n;
      tmr   <= tmr_n;
      out   <= (state_n == HIGH);
      if (acc) begin
        hi_q  <= hi_len;
        lo_q  <= lo_len;
        num_q <= num;
        sent  <= '0;
      end else if (state == HIGH && fin) begin
        sent <= sent + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: table-driven check of pulse patterns, status and corner sequences
module tb_pulse_train_gen;
  logic clk = 1'b0;
  logic rst, start, out, busy, done;
  logic [3:0] num, sent;
  logic [7:0] hi_len, lo_len;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [3:0]  num;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [63:0] pat;
    int          dc;
    logic [63:0] poke;
  } vec_t;

  vec_t vecs[6];

  pulse_train_gen #(.CNT_W(4), .TW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num(num), .hi_len(hi_len), .lo_len(lo_len),
    .out(out), .busy(busy), .done(done), .sent(sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int edges;
    logic prev;
    logic [3:0] es;
    edges = 0;
    prev = 1'b0;
    es = 4'd0;
    @(negedge clk);
    num = v.num;
    hi_len = v.hi;
    lo_len = v.lo;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= v.dc + 1; c++) begin
      if (c >= 2 && v.pat[c-2] && !v.pat[c-1]) es++;
      chk($sformatf("%s cyc%0d {out,busy,done,sent}", v.name, c), {25'd0, out, busy, done, sent},
          {25'd0, v.pat[c-1], (c <= v.dc), (c == v.dc), es});
      if (out && !prev) edges++;
      prev = out;
      if (v.poke[c]) begin
        start = 1'b1;
        num = 4'd7;
        hi_len = 8'd1;
        lo_len = 8'd1;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk($sformatf("%s rising edges", v.name), edges, {28'd0, v.num});
  endtask

  initial begin
    vecs[0] = '{"n3h2l3",  4'd3,  8'd2, 8'd3, 64'hC63,      16, 64'd0};
    vecs[1] = '{"n0",      4'd0,  8'd5, 8'd5, 64'h0,        1,  64'd0};
    vecs[2] = '{"n2h0l0",  4'd2,  8'd0, 8'd0, 64'h5,        5,  64'd0};
    vecs[3] = '{"n2h2l2poke", 4'd2, 8'd2, 8'd2, 64'h33,     9,  (64'd1 << 2) | (64'd1 << 4) | (64'd1 << 9)};
    vecs[4] = '{"n15h1l1", 4'd15, 8'd1, 8'd1, 64'h15555555, 31, 64'd0};
    vecs[5] = '{"n1h3l2",  4'd1,  8'd3, 8'd2, 64'h7,        6,  64'd0};
    rst = 1'b1;
    start = 1'b1;
    num = 4'd3;
    hi_len = 8'd2;
    lo_len = 8'd2;
    #1;
    chk("reset state", {28'd0, out, busy, done, sent[0]}, 32'd0);
    chk("reset sent", {28'd0, sent}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("start under rst ignored", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle after release", {29'd0, out, busy, done}, 32'd0);
    for (int i = 0; i < 6; i++) run(vecs[i]);
    chk("sent holds after done", {28'd0, sent}, 32'd1);
    @(negedge clk);
    num = 4'd4;
    hi_len = 8'd2;
    lo_len = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("second pulse high before rst", {28'd0, out, busy, sent[1:0]}, {28'd0, 2'b11, 2'd1});
    #1 rst = 1'b1;
    #1;
    chk("async rst clears", {25'd0, out, busy, done, sent}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("post rst idle cyc%0d", c), {25'd0, out, busy, done, sent}, 32'd0);
      @(negedge clk);
    end
    run('{"after rst n1", 4'd1, 8'd1, 8'd1, 64'h1, 3, 64'd0});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, giving the width of the pulse-count fields.
REQ-002 The block SHALL have parameter TW, default 8, giving the width of the phase-length fields.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, per the port lines below.
REQ-004 Port clk: input, 1 bit, single clock; all state SHALL update on its rising edge.
REQ-005 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-006 Port start: input, 1 bit, request to begin a pulse train; sampled on a clk edge.
REQ-007 Port num: input, CNT_W bits, number of pulses to emit; captured with start.
REQ-008 Port hi_len: input, TW bits, high-phase length in clk cycles; captured with start.
REQ-009 Port lo_len: input, TW bits, low-phase length in clk cycles; captured with start.
REQ-010 Port out: output, 1 bit, registered pulse train intended to drive an edge counter.
REQ-011 Port busy: output, 1 bit, high while a train is in progress.
REQ-012 Port done: output, 1 bit, single-cycle completion strobe.
REQ-013 Port sent: output, CNT_W bits, count of completed pulses in the current or last train.

Function
REQ-014 The FSM SHALL have four states: IDLE, HIGH, LOW and DONE.
REQ-015 In IDLE, start=1 SHALL be accepted: latch num/hi_len/lo_len, clear sent to 0, and go to HIGH, or to DONE if num==0.
REQ-016 A latched hi_len or lo_len of 0 SHALL be treated as 1.
REQ-017 out SHALL be 1 exactly in HIGH and 0 in every other state; the first out=1 cycle SHALL be the cycle after the accepting edge.
REQ-018 HIGH SHALL last exactly hi_len cycles, then go to LOW; sent SHALL increment by 1 on that transition.
REQ-019 LOW SHALL last exactly lo_len cycles, then go to HIGH if sent < latched num, else to DONE.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-021 busy SHALL be 1 in HIGH, LOW and DONE, and 0 in IDLE.
REQ-022 start SHALL be ignored outside IDLE, including the DONE cycle; the inputs SHALL NOT be re-latched mid-train.
REQ-023 Once accepted, a train of N pulses SHALL occupy exactly N*(hi+lo) cycles from the first out=1 to the DONE cycle.
REQ-024 sent SHALL hold its final value after DONE until the next accepted start.
REQ-025 num equal to 2^CNT_W-1 SHALL emit that many pulses without counter wrap.
REQ-026 The phase timer SHALL be TW bits wide, reload on each phase entry, and never wrap within a phase.
REQ-027 num==0 SHALL produce no out pulse, with done asserted one cycle after acceptance.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, with out=0, busy=0, done=0, sent=0 and the phase timer cleared, independent of clk.
REQ-029 A reset asserted mid-train SHALL abort the train with no done strobe; after release, the block SHALL accept the next start normally.
REQ-030 start SHALL NOT be accepted on any edge where rst=1.

Verification
REQ-031 The bench SHALL check: start with num=3, hi=2, lo=3 -> out pattern 11000 repeated 3 times, sent steps 1,2,3, done=1 on cycle 16 after acceptance, busy low after.
REQ-032 The bench SHALL check: start with num=0 -> out stays 0, done=1 one cycle after acceptance, sent=0.
REQ-033 The bench SHALL check: hi=0, lo=0, num=2 -> out pattern 1010, then done.
REQ-034 The bench SHALL check: a second start during HIGH/LOW/DONE with different num -> ignored; the original train completes unchanged.
REQ-035 The bench SHALL check: rst asserted during the 2nd pulse of num=4 -> out=0, busy=0, sent=0 at once, no done; a fresh start with num=1 then yields one pulse.
REQ-036 The bench SHALL check: num=15, hi=1, lo=1 -> 15 pulses, sent=15, and a downstream counter with CNT_MAX=8 sees 15 rising edges.
